// File: rtl/jtdd_sndcmd_pkg.sv
// Shared definitions for the main-to-sound command channel.
package jtdd_sndcmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        GAPW = 2'd3
    } state_t;

    localparam logic [7:0] LATCH_RST = 8'hff;

endpackage

// File: rtl/jtdd_sndcmd_fifo.sv
// Single-clock first-word-fall-through FIFO for queued command bytes.
// Push while full is accepted only if a pop happens in the same cycle.
module jtdd_sndcmd_fifo #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers are AW bits wide and wrap modulo depth on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/jtdd_sndcmd.sv
// Main-CPU side of the sound command channel: queues bytes, presents each on
// snd_latch with a rising snd_irq, holds until ack/timeout, then forces a low gap.
module jtdd_sndcmd
    import jtdd_sndcmd_pkg::*;
#(
    parameter int          AW   = 2,
    parameter logic [11:0] TOUT = 12'd2048,
    parameter logic [3:0]  GAP  = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       snd_ack,
    output logic [7:0] snd_latch,
    output logic       snd_irq,
    output logic       busy,
    output logic       full,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic [7:0] tout_cnt
);

    state_t      state;
    logic [11:0] timer;
    logic [3:0]  gap_cnt;
    logic [7:0]  fifo_dout;
    logic [AW:0] fifo_count;
    logic        fifo_empty;
    logic        pop;

    assign pop  = (state == IDLE) & ~fifo_empty;
    assign busy = (fifo_count != '0) | (state != IDLE);

    jtdd_sndcmd_fifo #(
        .AW (AW),
        .DW (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snd_latch <= LATCH_RST;
            snd_irq   <= 1'b0;
            timer     <= '0;
            gap_cnt   <= '0;
            tout_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            // A dropped write outranks a same-cycle clear so the loss is never hidden.
            if (wr && full && !pop) ovf <= 1'b1;
            else if (ovf_clr)       ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        snd_latch <= fifo_dout;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    snd_irq <= 1'b1;
                    timer   <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (snd_ack) begin
                        snd_irq <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAPW;
                    end else if (cen) begin
                        if (TOUT != 12'd0 && timer == TOUT - 12'd1) begin
                            snd_irq  <= 1'b0;
                            tout_cnt <= (tout_cnt == 8'hff) ? 8'hff : tout_cnt + 8'd1;
                            gap_cnt  <= '0;
                            state    <= GAPW;
                        end else begin
                            timer <= timer + 12'd1;
                        end
                    end
                end
                GAPW: begin
                    if (cen) begin
                        if (gap_cnt == GAP - 4'd1) state <= IDLE;
                        else                       gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_sndcmd.sv
// Directed bench for jtdd_sndcmd: AW=2, TOUT=16, GAP=4.
module tb_jtdd_sndcmd;

    logic       clk = 1'b0;
    logic       rst, cen, wr, snd_ack, ovf_clr;
    logic [7:0] din;
    logic [7:0] snd_latch, tout_cnt;
    logic       snd_irq, busy, full, ovf;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    jtdd_sndcmd #(.AW(2), .TOUT(12'd16), .GAP(4'd4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .wr        (wr),
        .din       (din),
        .snd_ack   (snd_ack),
        .snd_latch (snd_latch),
        .snd_irq   (snd_irq),
        .busy      (busy),
        .full      (full),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .tout_cnt  (tout_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr = 1'b1; din = b;
        tick();
        wr = 1'b0;
    endtask

    task automatic ack_pulse();
        snd_ack = 1'b1;
        tick();
        snd_ack = 1'b0;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (snd_irq !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; wr = 1'b0; din = 8'h00; snd_ack = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vec++; if (snd_latch !== 8'hff) begin err++; $display("FAIL reset_latch got=%h exp=ff", snd_latch); end
        vec++; if (snd_irq !== 1'b0) begin err++; $display("FAIL reset_irq got=%b exp=0", snd_irq); end
        vec++; if (busy !== 1'b0 || full !== 1'b0 || ovf !== 1'b0) begin err++; $display("FAIL reset_status got=%b%b%b exp=000", busy, full, ovf); end
        vec++; if (tout_cnt !== 8'h00) begin err++; $display("FAIL reset_tout got=%h exp=00", tout_cnt); end
    endtask

    task automatic test_single();
        wr_byte(8'h3a);
        tick();
        vec++; if (snd_irq !== 1'b0) begin err++; $display("FAIL single_irq_early got=%b exp=0", snd_irq); end
        vec++; if (snd_latch !== 8'h3a) begin err++; $display("FAIL single_latch got=%h exp=3a", snd_latch); end
        tick();
        vec++; if (snd_irq !== 1'b1) begin err++; $display("FAIL single_irq_rise got=%b exp=1", snd_irq); end
        repeat (10) tick();
        vec++; if (snd_irq !== 1'b1 || snd_latch !== 8'h3a) begin err++; $display("FAIL single_hold got=%b/%h exp=1/3a", snd_irq, snd_latch); end
        ack_pulse();
        vec++; if (snd_irq !== 1'b0) begin err++; $display("FAIL single_irq_fall got=%b exp=0", snd_irq); end
        repeat (3) tick();
        vec++; if (busy !== 1'b1 || snd_irq !== 1'b0) begin err++; $display("FAIL single_gap got=%b/%b exp=1/0", busy, snd_irq); end
        tick();
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL single_done_busy got=%b exp=0", busy); end
    endtask

    task automatic test_ack_outside();
        ack_pulse();
        vec++; if (busy !== 1'b0 || snd_irq !== 1'b0) begin err++; $display("FAIL ackidle got=%b/%b exp=0/0", busy, snd_irq); end
        wr_byte(8'h55);
        tick();
        ack_pulse();
        vec++; if (snd_irq !== 1'b1) begin err++; $display("FAIL ackload_irq got=%b exp=1", snd_irq); end
        tick(); tick();
        vec++; if (snd_irq !== 1'b1) begin err++; $display("FAIL ackload_hold got=%b exp=1", snd_irq); end
        ack_pulse();
        repeat (4) tick();
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL ackload_done got=%b exp=0", busy); end
    endtask

    task automatic test_burst();
        int n;
        logic [7:0] exp_b;
        wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 8'(i);
            tick();
        end
        wr = 1'b0;
        vec++; if (full !== 1'b0 || busy !== 1'b1) begin err++; $display("FAIL burst_full got=%b/%b exp=0/1", full, busy); end
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'(i + 1);
            wait_irq(n);
            vec++; if (n >= 100) begin err++; $display("FAIL burst_irq_timeout item=%0d waited=%0d", i, n); end
            vec++; if (snd_latch !== exp_b) begin err++; $display("FAIL burst_latch got=%h exp=%h", snd_latch, exp_b); end
            ack_pulse();
            if (i < 3) begin
                n = 0;
                while (snd_irq !== 1'b1 && n < 20) begin tick(); n++; end
                vec++; if (n != 6) begin err++; $display("FAIL burst_gap got=%0d exp=6", n); end
            end
        end
        repeat (4) tick();
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL burst_done got=%b exp=0", busy); end
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] exp_q [5];
        exp_q = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha7};
        wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 8'ha0 + 8'(i);
            tick();
        end
        wr = 1'b0;
        vec++; if (full !== 1'b1 || ovf !== 1'b1) begin err++; $display("FAIL ovf_set got=%b/%b exp=1/1", full, ovf); end
        vec++; if (snd_latch !== 8'ha0 || snd_irq !== 1'b1) begin err++; $display("FAIL ovf_inflight got=%h/%b exp=a0/1", snd_latch, snd_irq); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        vec++; if (ovf !== 1'b0) begin err++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
        ovf_clr = 1'b1; wr = 1'b1; din = 8'ha6; tick(); wr = 1'b0;
        vec++; if (ovf !== 1'b1) begin err++; $display("FAIL ovf_clr_vs_drop got=%b exp=1", ovf); end
        tick(); ovf_clr = 1'b0;
        vec++; if (ovf !== 1'b0) begin err++; $display("FAIL ovf_clr2 got=%b exp=0", ovf); end
        ack_pulse();
        repeat (4) tick();
        wr = 1'b1; din = 8'ha7; tick(); wr = 1'b0;
        vec++; if (full !== 1'b1 || ovf !== 1'b0) begin err++; $display("FAIL full_wr_pop got=%b/%b exp=1/0", full, ovf); end
        vec++; if (snd_latch !== 8'ha1) begin err++; $display("FAIL full_pop_latch got=%h exp=a1", snd_latch); end
        for (int i = 0; i < 5; i++) begin
            wait_irq(n);
            vec++; if (n >= 100) begin err++; $display("FAIL drain_irq_timeout item=%0d waited=%0d", i, n); end
            vec++; if (snd_latch !== exp_q[i]) begin err++; $display("FAIL drain_latch got=%h exp=%h", snd_latch, exp_q[i]); end
            ack_pulse();
        end
        repeat (5) tick();
        vec++; if (busy !== 1'b0 || tout_cnt !== 8'h00) begin err++; $display("FAIL drain_done got=%b/%h exp=0/00", busy, tout_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        wr_byte(8'hb0);
        wr_byte(8'hb1);
        tick();
        cen = 1'b0;
        repeat (20) tick();
        vec++; if (snd_irq !== 1'b1) begin err++; $display("FAIL tout_cen_gate got=%b exp=1", snd_irq); end
        cen = 1'b1;
        repeat (15) tick();
        vec++; if (snd_irq !== 1'b1) begin err++; $display("FAIL tout_early got=%b exp=1", snd_irq); end
        tick();
        vec++; if (snd_irq !== 1'b0 || tout_cnt !== 8'h01) begin err++; $display("FAIL tout_fire got=%b/%h exp=0/01", snd_irq, tout_cnt); end
        n = 0;
        while (snd_irq !== 1'b1 && n < 20) begin tick(); n++; end
        vec++; if (n != 6 || snd_latch !== 8'hb1) begin err++; $display("FAIL tout_next got=%0d/%h exp=6/b1", n, snd_latch); end
        repeat (15) tick();
        snd_ack = 1'b1; tick(); snd_ack = 1'b0;
        vec++; if (snd_irq !== 1'b0 || tout_cnt !== 8'h01) begin err++; $display("FAIL tout_ack_coincide got=%b/%h exp=0/01", snd_irq, tout_cnt); end
        repeat (3) tick();
        vec++; if (busy !== 1'b1) begin err++; $display("FAIL tout_ack_gap got=%b exp=1", busy); end
        tick();
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL tout_ack_done got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        wr = 1'b1;
        din = 8'hc0; tick();
        din = 8'hc1; tick();
        din = 8'hc2; tick();
        wr = 1'b0;
        vec++; if (snd_irq !== 1'b1 || snd_latch !== 8'hc0) begin err++; $display("FAIL rmid_pre got=%b/%h exp=1/c0", snd_irq, snd_latch); end
        rst = 1'b1; tick(); rst = 1'b0;
        vec++; if (snd_irq !== 1'b0 || snd_latch !== 8'hff) begin err++; $display("FAIL rmid_out got=%b/%h exp=0/ff", snd_irq, snd_latch); end
        vec++; if (busy !== 1'b0 || full !== 1'b0 || tout_cnt !== 8'h00) begin err++; $display("FAIL rmid_status got=%b/%b/%h exp=0/0/00", busy, full, tout_cnt); end
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ack_outside();
        test_burst();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vec=%0d err=%0d", vec, err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtdd_sndcmd.md
Name: jtdd_sndcmd

Overview:
- Main-CPU-side transmitter of the sound command channel: main CPU writes command bytes; block queues them and presents each to the sound subsystem as snd_latch plus a rising edge on snd_irq.
- Holds snd_irq high until the sound CPU reads the latch (snd_ack) or a timeout expires, then drops it for a guaranteed gap so the next rising edge is detectable.
- Sits in the main CPU address-decode area; outputs feed the sound block's snd_latch/snd_irq inputs directly.

Parameters:
- AW, 2, FIFO address width; depth = 2**AW entries.
- TOUT, 12'd2048, timeout in cen ticks waiting for snd_ack; 0 disables timeout.
- GAP, 4'd4, minimum snd_irq low time in cen ticks between commands (>=1).

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  synchronous reset, active high
- cen  in  1  clock enable for timeout/gap counters (main CPU cen)
- wr  in  1  one-cycle write strobe from main CPU decode
- din  in  8  command byte
- snd_ack  in  1  one-cycle pulse: sound CPU read of latch (sound-side latch_cs, synchronised by parent)
- snd_latch  out  8  byte presented to sound CPU
- snd_irq  out  1  interrupt request to sound CPU, rising edge significant
- busy  out  1  FIFO non-empty or command in flight
- full  out  1  FIFO full
- ovf  out  1  sticky: write dropped because full
- ovf_clr  in  1  clears ovf
- tout_cnt  out  8  saturating count of timed-out commands

Behaviour:
- Reset: snd_latch=8'hff, snd_irq=0, busy=0, full=0, ovf=0, tout_cnt=0, FIFO pointers and count 0, FSM=IDLE. Reset mid-operation discards queued and in-flight commands.
- FIFO: count width AW+1. Write on wr when not full; if full, byte dropped, ovf<=1. wr and pop in the same cycle are both honoured; count unchanged. When full, a pop and wr in the same cycle accept the write. ovf_clr and a dropping write in the same cycle: ovf stays 1.
- full = (count == 2**AW); busy = (count != 0) | (state != IDLE).
- FSM, clk domain (counters advance only on cen):
  - IDLE: if count != 0, pop head into snd_latch; go to LOAD.
  - LOAD (1 clk): snd_latch stable for a setup cycle; snd_irq<=1; clear timer; go to WAIT.
  - WAIT: snd_irq=1. On snd_ack: snd_irq<=0, go to GAP. Else on cen, timer++. If TOUT!=0 and timer==TOUT-1 on a cen: snd_irq<=0, tout_cnt++ (saturating at 8'hff), go to GAP. snd_ack wins if it coincides with the timeout.
  - GAPW: snd_irq=0. Count GAP cen ticks, then go to IDLE.
- Latency: a write into an empty, IDLE block raises snd_irq 3 clk later: wr→FIFO, IDLE pop, LOAD.
- snd_latch holds the last popped value until the next pop; it never changes while snd_irq=1.
- snd_ack outside WAIT is ignored.
- Pointer wrap: pointers are AW bits and wrap naturally modulo depth.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOAD, WAIT, GAPW) and the reset value of snd_latch (8'hff).
- One natural sub-module: jtdd_sndcmd_fifo, a single-clock FIFO with push/pop/count/full/empty and first-word output.
- Top level holds the FSM, counters and status.

Test Plan:
- Single command: wr din=8'h3a, ack 10 cen later → snd_latch=8'h3a, snd_irq rises 3 clk after wr, falls the clk after ack, stays low >=4 cen, busy ends 0.
- Burst of 4 writes (8'h01..8'h04), AW=2, ack each → four snd_irq pulses, latches 01,02,03,04 in order, each separated by >=GAP cen low, full asserted after the 4th write only while nothing has yet been popped.
- Overflow: 6 writes with no ack, TOUT=0 → ovf=1; exactly 4 bytes queued plus 1 in flight; ovf_clr → 0.
- Timeout: TOUT=16, single write, no ack → snd_irq low after 16 cen, tout_cnt=1, next queued byte presented after the gap.
- Coincident ack and timeout on the same cycle → tout_cnt unchanged, GAP entered. Simultaneous wr and pop while full → write accepted, ovf stays 0.
- Reset asserted while in WAIT with 2 queued → next clk: snd_irq=0, snd_latch=8'hff, busy=0; subsequent write behaves as the first test.
